thread_dispatcher: RTL

- Central dispatcher shared by NCPU per-CPU thread controllers.
- Accepts fork-thread and stop-thread requests, serialises them with a round-robin arbiter and queues forked threads in a ready FIFO.
- Tracks the count of live threads and acknowledges each request with a one-cycle done pulse.
- Idle CPUs pull the next ready thread from the FIFO head.

---
 rtl/thread_dispatcher_if.sv | 33 +++
 rtl/thread_dispatcher.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/thread_dispatcher_if.sv
// Bundles the request/acknowledge side and the ready-thread pop side of the dispatcher.
// slave = dispatcher, master = CPU-side controllers (or a testbench standing in for them).
interface thread_dispatcher_if #(
    parameter int NCPU   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 8
);
    logic                     disp_online;
    logic [NCPU-1:0]          req_valid;
    logic [NCPU-1:0]          req_stop;
    logic [NCPU*ADDR_W-1:0]   req_addr;
    logic [NCPU*DATA_W-1:0]   req_data;
    logic [NCPU-1:0]          done;
    logic                     done_err;
    logic                     thr_valid;
    logic [ADDR_W-1:0]        thr_addr;
    logic [DATA_W-1:0]        thr_data;
    logic                     thr_ready;
    logic [CNT_W-1:0]         live_cnt;
    logic [$clog2(DEPTH):0]   q_count;

    modport slave (
        input  req_valid, req_stop, req_addr, req_data, thr_ready,
        output disp_online, done, done_err, thr_valid, thr_addr, thr_data, live_cnt, q_count
    );

    modport master (
        output req_valid, req_stop, req_addr, req_data, thr_ready,
        input  disp_online, done, done_err, thr_valid, thr_addr, thr_data, live_cnt, q_count
    );
endinterface

// File: rtl/thread_dispatcher.sv
// Round-robin dispatcher for fork/stop requests from NCPU CPUs, feeding a ready-thread FIFO
// and tracking the number of live threads.
module thread_dispatcher #(
    parameter int NCPU   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    thread_dispatcher_if.slave bus,
    output logic [1:0]        dbg_state
);
    localparam int GW = (NCPU > 1) ? $clog2(NCPU) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int QW = PW + 1;

    // Handshakes: a request is valid while req_valid[i]=1 and is accepted when done[i] pulses;
    // the pop side transfers the head on any edge where thr_valid && thr_ready.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t              state;
    logic [GW-1:0]       rr_ptr;
    logic [GW-1:0]       gnt;
    logic                op;
    logic                err;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_data;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [QW-1:0]       q_count;
    logic [CNT_W-1:0]    live_cnt;
    logic [ADDR_W-1:0]   mem_addr [DEPTH];
    logic [DATA_W-1:0]   mem_data [DEPTH];

    logic [NCPU-1:0]     cand;
    logic [GW-1:0]       arb_idx;
    logic                arb_hit;
    logic                push;
    logic                pop;

    // The CPU whose done is showing may not have dropped req_valid yet; never re-grant it.
    assign cand = bus.req_valid & ~bus.done;

    always_comb begin
        int idx;
        idx     = 0;
        arb_hit = 1'b0;
        arb_idx = '0;
        for (int k = 0; k < NCPU; k++) begin
            idx = (int'(rr_ptr) + k) % NCPU;
            if (!arb_hit && cand[idx]) begin
                arb_hit = 1'b1;
                arb_idx = GW'(idx);
            end
        end
    end

    assign push = (state == EXEC) && !op && (q_count < QW'(DEPTH)) && (live_cnt != '1);
    assign pop  = bus.thr_ready && (q_count != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            gnt             <= '0;
            op              <= 1'b0;
            err             <= 1'b0;
            lat_addr        <= '0;
            lat_data        <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            q_count         <= '0;
            live_cnt        <= '0;
            bus.disp_online <= 1'b0;
            bus.done        <= '0;
            bus.done_err    <= 1'b0;
        end else begin
            bus.disp_online <= 1'b1;
            bus.done        <= '0;
            bus.done_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.disp_online && arb_hit) begin
                        gnt      <= arb_idx;
                        op       <= bus.req_stop[arb_idx];
                        lat_addr <= bus.req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
                        lat_data <= bus.req_data[int'(arb_idx)*DATA_W +: DATA_W];
                        rr_ptr   <= (arb_idx == GW'(NCPU-1)) ? '0 : arb_idx + 1'b1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (op) begin
                        if (live_cnt != '0) begin
                            live_cnt <= live_cnt - 1'b1;
                            err      <= 1'b0;
                        end else begin
                            err      <= 1'b1;
                        end
                        state <= ACK;
                    end else if (push) begin
                        live_cnt <= live_cnt + 1'b1;
                        err      <= 1'b0;
                        state    <= ACK;
                    end
                end
                ACK: begin
                    bus.done[gnt] <= 1'b1;
                    bus.done_err  <= err;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once q_count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= lat_addr;
            mem_data[wr_ptr] <= lat_data;
        end
    end

    assign bus.thr_valid = (q_count != '0);
    assign bus.thr_addr  = mem_addr[rd_ptr];
    assign bus.thr_data  = mem_data[rd_ptr];
    assign bus.live_cnt  = live_cnt;
    assign bus.q_count   = q_count;
    assign dbg_state     = state;
endmodule
